// File: rtl/cmd_pkg.sv
// cmd_pkg: command encodings, bit-FSM state type and default timing constants
// shared by the command packet receiver.
package cmd_pkg;
    localparam int BAUD_DIV_DEF    = 2604;
    localparam int GAP_TIMEOUT_DEF = 65536;

    typedef enum logic [7:0] {
        STPTCH  = 8'h02,
        STRLL   = 8'h03,
        STYW    = 8'h04,
        STTHRST = 8'h05,
        CAL     = 8'h06,
        EMER    = 8'h07,
        MTSOFF  = 8'h08
    } cmd_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } rx_state_t;
endpackage

// File: rtl/uart_rx_byte.sv
// uart_rx_byte: 8N1 byte receiver with mid-bit sampling, false-start rejection
// and stop-bit checking; start/valid/error are one-clock registered pulses.
module uart_rx_byte
    import cmd_pkg::*;
#(
    parameter int BAUD_DIV = BAUD_DIV_DEF
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rx,
    output logic [7:0] rx_byte,
    output logic       rx_valid,
    output logic       frm_err,
    output logic       start,
    output logic       idle
);
    localparam int BW = $clog2(BAUD_DIV + 1);

    logic            r_s1, r_s2, r_d;
    rx_state_t       r_state;
    logic [BW-1:0]   r_baud;
    logic [3:0]      r_bit;
    logic [7:0]      r_shift;
    logic            w_exp;

    // the baud counter counts down to 1, so a load of N samples N clocks later
    assign w_exp   = (r_baud == BW'(1));
    assign rx_byte = r_shift;
    assign idle    = (r_state == IDLE);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_s1     <= 1'b1;
            r_s2     <= 1'b1;
            r_d      <= 1'b1;
            r_state  <= IDLE;
            r_baud   <= '0;
            r_bit    <= '0;
            r_shift  <= '0;
            rx_valid <= 1'b0;
            frm_err  <= 1'b0;
            start    <= 1'b0;
        end else begin
            r_s1     <= rx;
            r_s2     <= r_s1;
            r_d      <= r_s2;
            rx_valid <= 1'b0;
            frm_err  <= 1'b0;
            start    <= 1'b0;
            if (r_state != IDLE && !w_exp)
                r_baud <= BW'(r_baud - 1'b1);
            case (r_state)
                IDLE: if (!r_s2 && r_d) begin
                    r_state <= START;
                    r_baud  <= BW'(BAUD_DIV / 2);
                    start   <= 1'b1;
                end
                START: if (w_exp) begin
                    r_state <= r_s2 ? IDLE : DATA;
                    r_baud  <= r_s2 ? '0 : BW'(BAUD_DIV);
                    r_bit   <= '0;
                end
                DATA: if (w_exp) begin
                    r_shift <= {r_s2, r_shift[7:1]};
                    r_bit   <= 4'(r_bit + 1'b1);
                    r_baud  <= BW'(BAUD_DIV);
                    if (r_bit == 4'd7)
                        r_state <= STOP;
                end
                STOP: if (w_exp) begin
                    r_state  <= IDLE;
                    r_baud   <= '0;
                    rx_valid <= r_s2;
                    frm_err  <= !r_s2;
                end
                default: r_state <= IDLE;
            endcase
        end
    end
endmodule

// File: rtl/cmd_packet_rx.sv
// cmd_packet_rx: assembles 3-byte command packets (cmd, data hi, data lo) from
// the serial byte receiver, with inter-byte gap timeout and cmd_rdy handshake.
module cmd_packet_rx
    import cmd_pkg::*;
#(
    parameter int BAUD_DIV    = BAUD_DIV_DEF,
    parameter int GAP_TIMEOUT = GAP_TIMEOUT_DEF
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        RX,
    input  logic        clr_cmd_rdy,
    output logic [7:0]  cmd,
    output logic [15:0] data,
    output logic        cmd_rdy,
    output logic        frm_err
);
    localparam int GW = $clog2(GAP_TIMEOUT + 1);

    logic [7:0]    w_byte;
    logic          w_valid, w_start, w_idle, w_timeout;
    logic [1:0]    r_idx;
    logic [7:0]    r_cmd_sh, r_hi_sh;
    logic [GW-1:0] r_gap;

    uart_rx_byte #(.BAUD_DIV(BAUD_DIV)) u_rx (
        .clk      (clk),
        .rst      (rst),
        .rx       (RX),
        .rx_byte  (w_byte),
        .rx_valid (w_valid),
        .frm_err  (frm_err),
        .start    (w_start),
        .idle     (w_idle)
    );

    assign w_timeout = (r_gap == GW'(GAP_TIMEOUT));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_idx    <= '0;
            r_cmd_sh <= '0;
            r_hi_sh  <= '0;
            r_gap    <= '0;
            cmd      <= '0;
            data     <= '0;
            cmd_rdy  <= 1'b0;
        end else begin
            if (w_valid) begin
                r_idx <= (r_idx == 2'd2) ? 2'd0 : 2'(r_idx + 1'b1);
                if (r_idx == 2'd0)
                    r_cmd_sh <= w_byte;
                if (r_idx == 2'd1)
                    r_hi_sh <= w_byte;
            end else if (frm_err || w_timeout) begin
                r_idx <= '0;
            end
            r_gap <= (w_start || r_idx == 2'd0 || w_timeout) ? '0 :
                     w_idle ? GW'(r_gap + 1'b1) : r_gap;
            // the low data byte bypasses its shadow so completion lands one clock after the stop sample
            if (w_valid && r_idx == 2'd2) begin
                cmd     <= r_cmd_sh;
                data    <= {r_hi_sh, w_byte};
                cmd_rdy <= 1'b1;
            end else if (clr_cmd_rdy || (w_start && r_idx == 2'd0)) begin
                cmd_rdy <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_cmd_packet_rx.sv
// tb_cmd_packet_rx: directed serial stimulus with a packet scoreboard popped on
// every rising cmd_rdy, plus direct checks of handshake, errors and reset.
module tb_cmd_packet_rx;
    localparam int B = 64;
    localparam int G = 1000;

    logic        clk = 1'b0;
    logic        rst, RX, clr_cmd_rdy;
    logic [7:0]  cmd;
    logic [15:0] data;
    logic        cmd_rdy, frm_err;

    logic [23:0] exp_q[$];
    int          n_pass = 0;
    int          n_tot = 0;
    int          fe_cnt = 0;
    int          f0;
    logic        rdy_d = 1'b0;

    cmd_packet_rx #(.BAUD_DIV(B), .GAP_TIMEOUT(G)) dut (
        .clk         (clk),
        .rst         (rst),
        .RX          (RX),
        .clr_cmd_rdy (clr_cmd_rdy),
        .cmd         (cmd),
        .data        (data),
        .cmd_rdy     (cmd_rdy),
        .frm_err     (frm_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tot++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    always @(negedge clk) begin
        if (frm_err === 1'b1)
            fe_cnt++;
        if (cmd_rdy === 1'b1 && rdy_d === 1'b0) begin
            if (exp_q.size() == 0)
                check("sb_unexpected", 32'(exp_q.size()), 32'd1);
            else
                check("sb_packet", {8'h0, cmd, data}, {8'h0, exp_q.pop_front()});
        end
        rdy_d = cmd_rdy;
    end

    task automatic send_head(input logic [7:0] b);
        RX = 1'b0;
        repeat (B) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            RX = b[i];
            repeat (B) @(negedge clk);
        end
    endtask

    task automatic send_byte(input logic [7:0] b, input logic stop = 1'b1);
        send_head(b);
        RX = stop;
        repeat (B) @(negedge clk);
        RX = 1'b1;
        repeat (4) @(negedge clk);
    endtask

    task automatic send_packet(input logic [7:0] c, input logic [7:0] hi, input logic [7:0] lo);
        exp_q.push_back({c, hi, lo});
        send_byte(c);
        send_byte(hi);
        send_byte(lo);
    endtask

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        rst = 1'b1;
        RX = 1'b1;
        clr_cmd_rdy = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_cmd", 32'(cmd), 32'h00);
        check("rst_data", 32'(data), 32'h0000);
        check("rst_rdy", 32'(cmd_rdy), 32'd0);
        check("rst_frm", 32'(frm_err), 32'd0);
        rst = 1'b0;
        repeat (5) @(negedge clk);

        send_packet(8'h06, 8'h00, 8'h00);
        check("p1_rdy", 32'(cmd_rdy), 32'd1);
        clr_cmd_rdy = 1'b1;
        @(negedge clk);
        clr_cmd_rdy = 1'b0;
        check("p1_clr", 32'(cmd_rdy), 32'd0);
        check("p1_hold", 32'(cmd), 32'h06);

        send_packet(8'h05, 8'h00, 8'hFF);
        check("p2_rdy", 32'(cmd_rdy), 32'd1);
        exp_q.push_back(24'h020100);
        RX = 1'b0;
        repeat (8) @(negedge clk);
        check("p3_start_rdy", 32'(cmd_rdy), 32'd0);
        check("p3_start_cmd", 32'(cmd), 32'h05);
        check("p3_start_data", 32'(data), 32'h00FF);
        repeat (B - 8) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            RX = 1'(8'h02 >> i);
            repeat (B) @(negedge clk);
        end
        RX = 1'b1;
        repeat (B + 4) @(negedge clk);
        send_byte(8'h01);
        send_byte(8'h00);
        check("p3_rdy", 32'(cmd_rdy), 32'd1);
        check("p3_data", 32'(data), 32'h0100);

        f0 = fe_cnt;
        RX = 1'b0;
        repeat (12) @(negedge clk);
        RX = 1'b1;
        repeat (2 * B) @(negedge clk);
        check("glitch_frm", 32'(fe_cnt - f0), 32'd0);
        send_packet(8'h07, 8'h00, 8'h00);
        check("glitch_cmd", 32'(cmd), 32'h07);

        f0 = fe_cnt;
        send_byte(8'h03, 1'b0);
        repeat (B) @(negedge clk);
        check("frm_pulse", 32'(fe_cnt - f0), 32'd1);
        send_packet(8'h04, 8'h12, 8'h34);
        check("frm_next", {8'h0, cmd, data}, 32'h041234);

        send_byte(8'h08);
        send_byte(8'hAB);
        repeat (G + 10) @(negedge clk);
        send_packet(8'h06, 8'h00, 8'h00);
        check("gap_pkt", {8'h0, cmd, data}, 32'h060000);

        exp_q.push_back(24'h035AA5);
        send_byte(8'h03);
        send_byte(8'h5A);
        clr_cmd_rdy = 1'b1;
        send_head(8'hA5);
        RX = 1'b1;
        for (int i = 0; i < B; i++) begin
            @(negedge clk);
            if (cmd_rdy) break;
        end
        clr_cmd_rdy = 1'b0;
        check("coinc_rdy", 32'(cmd_rdy), 32'd1);
        @(negedge clk);
        check("coinc_hold", 32'(cmd_rdy), 32'd1);
        repeat (B) @(negedge clk);

        RX = 1'b0;
        repeat (B) @(negedge clk);
        RX = 1'b1;
        repeat (2 * B + 7) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        check("arst_cmd", 32'(cmd), 32'h00);
        check("arst_data", 32'(data), 32'h0000);
        check("arst_rdy", 32'(cmd_rdy), 32'd0);
        check("arst_frm", 32'(frm_err), 32'd0);
        RX = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        repeat (20) @(negedge clk);
        send_packet(8'h04, 8'hAB, 8'hCD);
        check("arst_next", {8'h0, cmd, data}, 32'h04ABCD);

        repeat (4) @(negedge clk);
        check("sb_drained", 32'(exp_q.size()), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end
endmodule

// File: doc/cmd_packet_rx.md
CMD_PACKET_RX -- requirements
Module: cmd_packet_rx

Interface
REQ-001 The parameter list SHALL be: BAUD_DIV, default 2604, clocks per bit (50 MHz at 19200 baud).
REQ-002 The parameter list SHALL also include: GAP_TIMEOUT, default 65536, maximum clocks allowed between bytes of one packet.
REQ-003 The ports SHALL be, in order:
- clk  input  1  single system clock, all logic on posedge
- rst  input  1  asynchronous, active-high reset
- RX  input  1  serial line from host, idles high
- clr_cmd_rdy  input  1  consumer acknowledge, knocks down cmd_rdy
- cmd  output  8  command byte of last complete packet
- data  output  16  data word of last complete packet
- cmd_rdy  output  1  complete packet available
- frm_err  output  1  one-clock pulse on bad stop bit

Function
REQ-004 RX SHALL pass through a 2-flop synchronizer; both flops reset to 1.
REQ-005 The bit FSM SHALL have states IDLE, START, DATA and STOP.
REQ-006 IDLE->START SHALL occur on a synchronized falling edge of RX, loading the baud counter with BAUD_DIV/2.
REQ-007 START SHALL sample RX at counter expiry.
- RX=1: false start, return to IDLE with no byte produced.
- RX=0: go to DATA with the counter reloaded to BAUD_DIV.
REQ-008 DATA SHALL shift in 8 bits LSB first, one sample per BAUD_DIV clocks, counted by a 4-bit bit counter, then go to STOP.
REQ-009 STOP SHALL sample once, then return to IDLE.
- Sample=1: byte valid.
- Sample=0: frm_err pulses for one clock, byte discarded, packet byte index cleared to 0.
REQ-010 Packet byte index SHALL be 0..2.
- Byte 0 goes to a cmd shadow register.
- Byte 1 goes to data[15:8] shadow; byte 2 goes to data[7:0] shadow.
- Index wraps to 0 after byte 2.
REQ-011 On valid byte 2, cmd and data SHALL update from the shadows on the next clock, and cmd_rdy SHALL assert that same clock (latency 1 clock after the stop-bit sample).
REQ-012 cmd and data SHALL change only at packet completion and hold otherwise.
REQ-013 cmd_rdy SHALL clear on clr_cmd_rdy, or on start-bit detection when the byte index is 0.
REQ-014 If packet completion and clr_cmd_rdy coincide, completion SHALL win and cmd_rdy=1.
REQ-015 A gap counter SHALL run while the byte index is nonzero and the FSM is IDLE; reaching GAP_TIMEOUT SHALL reset the byte index to 0 and discard the partial packet with no error pulse.
REQ-016 The gap counter SHALL clear on every start-bit detection.
REQ-017 Counter widths SHALL be $clog2 of their maxima; there SHALL be no wrap-around inside a bit period.

Reset
REQ-018 rst SHALL asynchronously force:
- FSM to IDLE
- byte index, baud, bit and gap counters to 0
- cmd=8'h00, data=16'h0000, cmd_rdy=0, frm_err=0
- shadows to 0
REQ-019 Reset mid-byte or mid-packet SHALL discard all partial data; the first falling edge after release SHALL start byte 0.

Structure
REQ-020 Command encodings SHALL live in shared package cmd_pkg, alongside the bit-FSM state typedef and the default BAUD_DIV constant: STPTCH 8'h02, STRLL 8'h03, STYW 8'h04, STTHRST 8'h05, CAL 8'h06, EMER 8'h07, MTSOFF 8'h08.
REQ-021 Bit-level reception SHALL be a sub-module uart_rx_byte with outputs rx_byte[7:0], rx_valid pulse and frm_err pulse.
REQ-022 Packet assembly, gap timer and handshake SHALL live in cmd_packet_rx.

Verification
REQ-023 Send bytes 06,00,00 -> cmd=8'h06, data=16'h0000, cmd_rdy=1 one clock after the third stop-bit sample; pulse clr_cmd_rdy -> cmd_rdy=0 next clock.
REQ-024 Send 05,00,FF then 02,01,00 with no clear -> cmd=8'h05, data=16'h00FF after the first packet; at the second packet's start bit cmd_rdy=0, cmd/data still hold 05/00FF; at completion cmd=8'h02, data=16'h0100, cmd_rdy=1.
REQ-025 Send a 600-clock low glitch on RX -> no byte, no frm_err; a following 07,00,00 packet decodes as cmd=8'h07.
REQ-026 Send byte 03 with stop bit=0 -> frm_err high exactly one clock; a following 04,12,34 packet decodes as cmd=8'h04, data=16'h1234.
REQ-027 Send 08,AB, idle GAP_TIMEOUT+10 clocks, then 06,00,00 -> cmd=8'h06, data=16'h0000, with the partial packet discarded.
REQ-028 Two cases:
- Assert clr_cmd_rdy on the completion clock -> cmd_rdy=1.
- Assert rst mid-byte -> all outputs 0 immediately; the next packet decodes correctly.
